// File: rtl/rs_age_alloc.sv
// Allocation and age tracking for an 8-entry reservation station.
// Exports the {~rdy, sortbit, tag} age keys used by the oldest-ready select tree.
module rs_age_alloc #(
    parameter int RRF_SEL = 6,
    parameter int ENTLEN  = 3,
    localparam int VALLEN = RRF_SEL + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dp_req0,
    input  logic                  dp_req1,
    input  logic [RRF_SEL-1:0]    dp_tag0,
    input  logic [RRF_SEL-1:0]    dp_tag1,
    input  logic                  dp_rdy0,
    input  logic                  dp_rdy1,
    input  logic                  rrf_wrap,
    input  logic [7:0]            wake_vec,
    input  logic                  iss_vld,
    input  logic [ENTLEN-1:0]     iss_ent,
    input  logic                  kill,
    output logic [ENTLEN-1:0]     dp_ent0,
    output logic [ENTLEN-1:0]     dp_ent1,
    output logic                  stall,
    output logic [3:0]            busy_cnt,
    output logic                  iss_ready,
    output logic [8*ENTLEN-1:0]   entvec,
    output logic [8*VALLEN-1:0]   valvec
);

    logic [7:0]                 valid_r, rdy_r, sort_r;
    logic [7:0][RRF_SEL-1:0]    tag_r;
    logic [7:0]                 valid_s, rdy_s, sort_s;
    logic [7:0][RRF_SEL-1:0]    tag_s;

    logic [ENTLEN-1:0]          ent0_s, ent1_s;
    logic                       found0_s, found1_s;
    logic [3:0]                 busy_s;
    logic                       stall_s;
    logic                       we0_s, we1_s, wrap_clr_s, sort0_s;

    // Lowest and second-lowest free entries, taken from registered valid only
    always_comb begin
        ent0_s   = {ENTLEN{1'b0}};
        ent1_s   = {ENTLEN{1'b0}};
        found0_s = 1'b0;
        found1_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!valid_r[i]) begin
                if (!found0_s) begin
                    ent0_s   = ENTLEN'(i);
                    found0_s = 1'b1;
                end else if (!found1_s) begin
                    ent1_s   = ENTLEN'(i);
                    found1_s = 1'b1;
                end else begin
                    ent1_s   = ent1_s;
                end
            end else begin
                ent0_s = ent0_s;
            end
        end
    end

    // Occupancy count and the derived full indication
    always_comb begin
        busy_s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            busy_s = busy_s + {3'b000, valid_r[i]};
        end
        stall_s = (busy_s > 4'd6);
    end

    // Write enables; slot 0 is pre-wrap only when a dual dispatch straddles the wrap
    always_comb begin
        we0_s      = dp_req0 & ~stall_s & ~kill;
        we1_s      = dp_req1 & ~stall_s & ~kill;
        wrap_clr_s = rrf_wrap & (we0_s | we1_s);
        sort0_s    = ~(rrf_wrap & we0_s & we1_s & (dp_tag0 > dp_tag1));
    end

    // Per-entry next state: kill > issue > dispatch write > wakeup / wrap clear
    always_comb begin
        valid_s = valid_r;
        rdy_s   = rdy_r;
        sort_s  = sort_r;
        tag_s   = tag_r;
        for (int i = 0; i < 8; i++) begin
            if (kill) begin
                valid_s[i] = 1'b0;
                rdy_s[i]   = 1'b0;
            end else if (iss_vld && (iss_ent == ENTLEN'(i))) begin
                valid_s[i] = 1'b0;
                rdy_s[i]   = 1'b0;
            end else if (we0_s && (ent0_s == ENTLEN'(i))) begin
                valid_s[i] = 1'b1;
                rdy_s[i]   = dp_rdy0;
                sort_s[i]  = sort0_s;
                tag_s[i]   = dp_tag0;
            end else if (we1_s && (ent1_s == ENTLEN'(i))) begin
                valid_s[i] = 1'b1;
                rdy_s[i]   = dp_rdy1;
                sort_s[i]  = 1'b1;
                tag_s[i]   = dp_tag1;
            end else begin
                if (wake_vec[i] && valid_r[i]) begin
                    rdy_s[i] = 1'b1;
                end else begin
                    rdy_s[i] = rdy_r[i];
                end
                if (wrap_clr_s && valid_r[i]) begin
                    sort_s[i] = 1'b0;
                end else begin
                    sort_s[i] = sort_r[i];
                end
            end
        end
    end

    // Entry state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 8'd0;
            rdy_r   <= 8'd0;
            sort_r  <= 8'd0;
            tag_r   <= '0;
        end else begin
            valid_r <= valid_s;
            rdy_r   <= rdy_s;
            sort_r  <= sort_s;
            tag_r   <= tag_s;
        end
    end

    // Output buses; invalid entries read as all ones so they never win selection
    always_comb begin
        entvec = {(8*ENTLEN){1'b0}};
        valvec = {(8*VALLEN){1'b1}};
        for (int i = 0; i < 8; i++) begin
            entvec[i*ENTLEN +: ENTLEN] = ENTLEN'(i);
            if (valid_r[i]) begin
                valvec[i*VALLEN +: VALLEN] = {~rdy_r[i], sort_r[i], tag_r[i]};
            end else begin
                valvec[i*VALLEN +: VALLEN] = {VALLEN{1'b1}};
            end
        end
        dp_ent0   = ent0_s;
        dp_ent1   = ent1_s;
        stall     = stall_s;
        busy_cnt  = busy_s;
        iss_ready = |(valid_r & rdy_r);
    end

endmodule

// File: doc/rs_age_alloc.md
# rs_age_alloc

Allocation and age-tracking front end for an 8-entry reservation station. It accepts up to two dispatched instructions per cycle and places each in a free entry. It stamps each entry with its RRF tag and a wrap-correcting sort bit, tracks operand readiness and frees entries on issue. Its outputs are the packed `entvec`/`valvec` buses consumed by the 8-way oldest-ready selection tree, with value layout `{~rdy, sortbit, rrftag}`.

## Interface
- `RRF_SEL`, default 6: RRF tag width.
- `ENTLEN`, default 3: entry index width; fixed to 8 entries.
- `VALLEN`, localparam = `RRF_SEL+2`: per-entry age value width.

- `clk` in 1: clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `dp_req0`, `dp_req1` in 1: dispatch slot request. Slot 0 is older in program order.
- `dp_tag0`, `dp_tag1` in `RRF_SEL`: RRF tag for each slot.
- `dp_rdy0`, `dp_rdy1` in 1: all operands of the slot are ready at dispatch.
- `rrf_wrap` in 1: the RRF allocation pointer wrapped with this cycle's dispatch.
- `wake_vec` in 8: per-entry "operands now ready" pulses.
- `iss_vld` in 1, `iss_ent` in `ENTLEN`: the selected entry issued this cycle and is to be freed.
- `kill` in 1: pipeline flush.
- `dp_ent0`, `dp_ent1` out `ENTLEN`: entries allocated to slot 0 and slot 1.
- `stall` out 1: fewer than 2 free entries.
- `busy_cnt` out 4: number of valid entries, 0..8.
- `iss_ready` out 1: at least one entry is valid and ready.
- `entvec` out `8*ENTLEN`: constant; field i = i.
- `valvec` out `8*VALLEN`: per-entry age value; field i sits at bits `[i*VALLEN +: VALLEN]`.

## Operation
- Per-entry state registers: `valid`, `rdy`, `sortbit`, `tag`.
- **Allocation:**
  - `dp_ent0` is the lowest-index entry with `valid`=0.
  - `dp_ent1` is the second-lowest such entry.
  - Both are computed from registered `valid` only.
  - When fewer free entries exist, the outputs are don't-care.
- **Write gating:** a slot writes its entry only when `dp_reqN & ~stall & ~kill`. Requests while `stall`=1 are dropped; the dispatcher must hold them.
- **Single-slot dispatch:** `dp_req1` without `dp_req0` is legal. The instruction is written into `dp_ent1`.
- **Entry write:** sets `valid`=1, `tag`=`dp_tagN`, `rdy`=`dp_rdyN`, `sortbit` per the rules below.
- **Sortbit:**
  - A newly written entry gets `sortbit`=1.
  - Exception: when `rrf_wrap`=1, both slots dispatch, and `dp_tag0 > dp_tag1`, slot 0 is pre-wrap and gets `sortbit`=0.
  - When `rrf_wrap`=1 and dispatch is accepted, every entry valid before this edge has `sortbit` cleared to 0.
- **Wakeup:** `wake_vec[i]` sets `rdy[i]` only if `valid[i]` was already 1. Wakeup on an entry being written the same cycle is ignored.
- **Issue:** `iss_vld` clears `valid[iss_ent]` and `rdy[iss_ent]`, whatever the entry's state.
- **`valvec` field i:**
  - Valid entry: `{~rdy[i], sortbit[i], tag[i]}`.
  - Invalid entry: all ones.
  - Effect: invalid and not-ready entries always compare larger than ready ones; older entries compare smaller.
- **Derived outputs:**
  - `iss_ready` = OR over i of `valid[i] & rdy[i]`.
  - `stall` = (free count < 2).
  - `busy_cnt` = popcount of `valid`.
- **Priority per entry:** `kill` > issue-free > dispatch write > wakeup.
  - `kill` clears all `valid` and `rdy`; `sortbit` and `tag` are don't-care afterwards.
  - An entry freed by issue this cycle is not allocatable until the next cycle, because allocation uses registered `valid`.

## Timing
- Reset value of every state bit is 0.
- Output values during and after reset:
  - `valvec` all ones.
  - `entvec` = {7,6,…,0}.
  - `stall`, `iss_ready`, `busy_cnt` = 0.
  - `dp_ent0`=0, `dp_ent1`=1.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Every output is a function of registers only; there is no combinational input-to-output path.
- Dispatch accepted at edge N: the entry appears in `valvec`, `busy_cnt`, `stall` and `iss_ready` after edge N.
- Wakeup or issue at edge N takes effect in outputs after edge N.
- Full condition: `busy_cnt`=7 or 8 gives `stall`=1. A single-slot dispatch with 1 free entry is also blocked.

## Test plan
- **Reset, then dual dispatch:** reset, then dispatch tags 5 (rdy) and 6 (not rdy).
  - Before the edge: `dp_ent0`=0, `dp_ent1`=1.
  - After the edge: `valvec[0]`=`{0,1,5}`, `valvec[1]`=`{1,1,6}`, `busy_cnt`=2, `iss_ready`=1.
- **Fill to stall:** dispatch 4 cycles of 2.
  - After the 3rd cycle: `stall`=0.
  - After the 4th cycle: `stall`=1, `busy_cnt`=8.
  - A 5th request is dropped and `busy_cnt` stays 8.
- **Issue frees entry:** with all 8 full, issue entry 3.
  - Next cycle: `valvec[3]` all ones, `busy_cnt`=7, `stall`=1, `dp_ent0`=3.
  - Same-cycle dispatch is not written into entry 3.
- **Wrap straddle:** entry 0 holds tag 62; dispatch tags 63 and 0 with `rrf_wrap`=1.
  - Entry 0 and the tag-63 entry have `sortbit`=0; the tag-0 entry has `sortbit`=1.
  - Oldest-ready order is 62 < 63 < 0.
- **Wakeup rules:** `wake_vec`=8'h04 on valid not-ready entry 2 sets `rdy[2]`.
  - The same pulse on an empty entry, or on an entry being written that cycle, leaves `rdy`=`dp_rdy`.
- **Kill and async reset:**
  - `kill` together with a dispatch and an issue: next cycle all `valvec` all ones, `busy_cnt`=0.
  - Asserting `reset` between clock edges clears all outputs immediately.
